// File: rtl/dsi_wishbone_csr_bridge.sv
// Pipelined Wishbone slave to CSR strobe bridge with an in-order request queue for the DSI register file.
// Strobe 2 cycles after accept, write ack +1, read ack +1+RD_LATENCY; stalls only when the queue is full.
module dsi_wishbone_csr_bridge #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk_wb_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    output logic                wb_ack_o,
    output logic                wb_stall_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [ADDR_W-1:0]   csr_adr_o,
    output logic [DATA_W-1:0]   csr_dat_o,
    output logic [DATA_W/8-1:0] csr_sel_o,
    output logic                csr_wr_o,
    output logic                csr_rd_o,
    input  logic [DATA_W-1:0]   csr_dat_i,
    output logic                busy_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
    } req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ_WAIT} state_t;

    req_t        r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_abort;
    logic        r_ack, r_wr, r_rd;
    logic [DATA_W-1:0] r_rdat, r_dat;
    logic [ADDR_W-1:0] r_adr;
    logic [SEL_W-1:0]  r_sel;

    req_t w_push_req, w_head;
    logic w_full, w_empty, w_push, w_pop, w_data_cyc;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign wb_stall_o = rst_i | w_full;
    assign w_push     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign w_push_req = '{we: wb_we_i, adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i};
    assign w_head     = r_mem[r_rptr];
    assign w_data_cyc = (r_state == ST_READ_WAIT) && (r_cnt == 3'd0);

    // An aborted read drains to IDLE before the engine may pop again.
    assign w_pop = wb_cyc_i && !w_empty &&
                   (r_state == ST_IDLE || r_state == ST_WRITE || (w_data_cyc && !r_abort));

    always_ff @(posedge clk_wb_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_req;
        end
    end

    always_ff @(posedge clk_wb_i) begin
        if (rst_i || !wb_cyc_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_wb_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_abort <= 1'b0;
            r_ack   <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_rdat  <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            case (r_state)
                ST_WRITE: r_ack <= wb_cyc_i;
                ST_READ_WAIT: begin
                    if (w_data_cyc) begin
                        if (wb_cyc_i && !r_abort) begin
                            r_ack  <= 1'b1;
                            r_rdat <= csr_dat_i;
                        end
                        r_abort <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                        if (!wb_cyc_i) r_abort <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_pop) begin
                r_adr <= w_head.adr;
                r_dat <= w_head.dat;
                r_sel <= w_head.sel;
                if (w_head.we) begin
                    r_wr    <= 1'b1;
                    r_state <= ST_WRITE;
                end else begin
                    r_rd    <= 1'b1;
                    r_cnt   <= 3'(RD_LATENCY);
                    r_state <= ST_READ_WAIT;
                end
            end else if (r_state == ST_WRITE || w_data_cyc) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_rdat;
    assign csr_adr_o = r_adr;
    assign csr_dat_o = r_dat;
    assign csr_sel_o = r_sel;
    assign csr_wr_o  = r_wr;
    assign csr_rd_o  = r_rd;
    assign busy_o    = !w_empty || (r_state != ST_IDLE);

endmodule
